// File: rtl/computer_pkg.sv
// computer_pkg: types and constants shared by the memory slot arbiter blocks.
//   slot_owner_e : which requester owns the current memory slot
//   arb_state_e  : per-slot memory transaction progress
//   DATA_W       : system memory data width
package computer_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic {
    SLOT_VID = 1'b0,
    SLOT_CPU = 1'b1
  } slot_owner_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_e;

  // Slots strictly alternate, so the next owner is always the other one.
  function automatic slot_owner_e other_owner(slot_owner_e owner);
    return (owner == SLOT_VID) ? SLOT_CPU : SLOT_VID;
  endfunction

endpackage

// File: rtl/slot_timer.sv
// slot_timer: free-running slot counter for the time-division memory arbiter.
// Ports:
//   CLOCK_50   in  system clock
//   reset      in  synchronous active-high reset
//   cnt        out position within the current slot, 0..SLOT_CYCLES-1
//   owner      out owner of the current slot (VID, CPU, VID, ...)
//   slot_start out high in the last cycle of a slot; the next edge begins a new
//                  slot with cnt=0 and the other owner
module slot_timer
  import computer_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = 20,
  localparam int unsigned CNT_W = $clog2(SLOT_CYCLES)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt,
  output slot_owner_e      owner,
  output logic             slot_start
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(SLOT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_owner_e      owner_q, owner_d;

  assign slot_start = (cnt_q == CntMax);

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    owner_d = owner_q;
    if (slot_start) begin
      cnt_d   = '0;
      owner_d = other_owner(owner_q);
    end
  end

  // Reset parks the timer at the end of a CPU slot so the first running edge
  // opens a video slot at cnt=0.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q   <= CntMax;
      owner_q <= SLOT_CPU;
    end else begin
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  assign cnt   = cnt_q;
  assign owner = owner_q;

endmodule

// File: rtl/mem_slot_arbiter.sv
// mem_slot_arbiter: fixed time-division arbiter sharing one synchronous 8-bit
// RAM between the CPU and the video scanner. Slots alternate VID, CPU, ...;
// an unused slot stays idle. A granted slot issues at cnt=0, lets the RAM
// output settle at cnt=1 and acks at cnt=2.
// Ports:
//   CLOCK_50, reset                    clock, synchronous active-high reset
//   cpu_req/we/addr/wdata, cpu_ack/rdata   CPU master (read or write)
//   vid_req/addr, vid_ack/rdata            video master (read only)
//   mem_en/we/addr/wdata, mem_rdata        RAM port (read data one cycle late)
//   vid_slot                               high while video owns the slot
module mem_slot_arbiter
  import computer_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned SLOT_CYCLES = 20
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              vid_slot
);

  localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);

  logic [CNT_W-1:0] cnt;
  slot_owner_e      owner;
  slot_owner_e      next_owner;
  logic             slot_start;
  logic             next_req;
  logic             grant;

  arb_state_e        state_q, state_d;
  slot_owner_e       txn_owner_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] vid_rdata_q;

  slot_timer #(
    .SLOT_CYCLES(SLOT_CYCLES)
  ) u_slot_timer (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .cnt       (cnt),
    .owner     (owner),
    .slot_start(slot_start)
  );

  // Only the incoming owner's request is looked at; an idle slot is never lent.
  assign next_owner = other_owner(owner);
  assign next_req   = (next_owner == SLOT_VID) ? vid_req : cpu_req;
  assign grant      = slot_start && next_req;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (grant) begin
      state_d = ISSUE;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      txn_owner_q <= SLOT_CPU;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      // Bus fields are latched once per granted slot and held afterwards.
      if (grant) begin
        txn_owner_q <= next_owner;
        if (next_owner == SLOT_VID) begin
          mem_we_q   <= 1'b0;
          mem_addr_q <= vid_addr;
        end else begin
          mem_we_q    <= cpu_we;
          mem_addr_q  <= cpu_addr;
          mem_wdata_q <= cpu_wdata;
        end
      end
      // RAM data is valid during WAIT; capture it for the DONE cycle.
      if (state_q == WAIT) begin
        if (txn_owner_q == SLOT_VID) begin
          vid_rdata_q <= mem_rdata;
        end else if (!mem_we_q) begin
          cpu_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = (state_q == DONE) && (txn_owner_q == SLOT_CPU);
  assign vid_ack   = (state_q == DONE) && (txn_owner_q == SLOT_VID);
  assign cpu_rdata = cpu_rdata_q;
  assign vid_rdata = vid_rdata_q;
  assign vid_slot  = (owner == SLOT_VID);

  // An access is only ever launched in the first cycle of its slot.
  assert property (@(posedge CLOCK_50) disable iff (reset) (state_q == ISSUE) |-> (cnt == '0));

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// tb_mem_slot_arbiter: scenario tasks plus randomized traffic, compared cycle
// by cycle against a slot-arithmetic reference model and a reference memory.
module tb_mem_slot_arbiter;

  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        vid_req = 1'b0;
  logic [15:0] vid_addr = '0;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        vid_slot;

  int vectors = 0;
  int miscompares = 0;

  mem_slot_arbiter #(
    .ADDR_W     (16),
    .SLOT_CYCLES(SC)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack  (cpu_ack),
    .cpu_rdata(cpu_rdata),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_ack  (vid_ack),
    .vid_rdata(vid_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .vid_slot (vid_slot)
  );

  always #5 clk = ~clk;

  // Synchronous RAM seen by the DUT.
  logic [7:0] ram    [0:65535];
  // Reference copy updated by the model when it predicts a write.
  logic [7:0] refmem [0:65535];

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] = mem_wdata;
    end
  end

  // Reference model: cycle index t since reset release; slot = t/SC, position
  // = t%SC, even slots belong to video.
  int          t = -1;
  int          m_tn, m_pos;
  bit          m_ov, m_g;
  bit          gr, gvid, gwe;
  logic [15:0] ga;
  logic        exp_mem_en = 0, exp_mem_we = 0, exp_cpu_ack = 0, exp_vid_ack = 0;
  logic        exp_vid_slot = 0;
  logic [15:0] exp_mem_addr = '0;
  logic [7:0]  exp_mem_wdata = '0, exp_cpu_rdata = '0, exp_vid_rdata = '0;

  always @(posedge clk) begin
    if (reset) begin
      t <= -1;
      gr <= 1'b0;
      exp_mem_en <= 0; exp_mem_we <= 0; exp_mem_addr <= '0; exp_mem_wdata <= '0;
      exp_cpu_ack <= 0; exp_vid_ack <= 0; exp_cpu_rdata <= '0; exp_vid_rdata <= '0;
      exp_vid_slot <= 0;
    end else begin
      m_tn  = t + 1;
      m_pos = m_tn % SC;
      m_ov  = ((m_tn / SC) % 2) == 0;
      t <= m_tn;
      exp_vid_slot <= m_ov;
      exp_mem_en <= 0;
      exp_cpu_ack <= 0;
      exp_vid_ack <= 0;
      if (m_pos == 0) begin
        m_g = m_ov ? vid_req : cpu_req;
        gr <= m_g;
        gvid <= m_ov;
        if (m_g) begin
          exp_mem_en <= 1;
          if (m_ov) begin
            exp_mem_addr <= vid_addr; exp_mem_we <= 0; ga <= vid_addr; gwe <= 0;
          end else begin
            exp_mem_addr <= cpu_addr; exp_mem_we <= cpu_we; exp_mem_wdata <= cpu_wdata;
            ga <= cpu_addr; gwe <= cpu_we;
            if (cpu_we) refmem[cpu_addr] = cpu_wdata;
          end
        end
      end else if (m_pos == 2 && gr) begin
        if (gvid) begin
          exp_vid_ack <= 1; exp_vid_rdata <= refmem[ga];
        end else begin
          exp_cpu_ack <= 1;
          if (!gwe) exp_cpu_rdata <= refmem[ga];
        end
      end
    end
  end

  logic [44:0] obs_vec, exp_vec;
  assign obs_vec = {mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, cpu_rdata,
                    vid_ack, vid_rdata, vid_slot};
  assign exp_vec = {exp_mem_en, exp_mem_we, exp_mem_addr, exp_mem_wdata, exp_cpu_ack,
                    exp_cpu_rdata, exp_vid_ack, exp_vid_rdata, exp_vid_slot};

  // Advance to the cycle at slot position p of a video (vid=1) or CPU slot.
  task automatic sync_to(input int p, input bit vid);
    bit found = 0;
    for (int k = 0; k < 16 && !found; k++) begin
      @(posedge clk); #1;
      if (t >= 0 && (t % SC) == p && (((t / SC) % 2) == 0) == vid) found = 1;
    end
    if (!found) begin
      vectors++; miscompares++;
      $display("FAIL sync_to: slot position %0d not reached, t=%0d", p, t);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (obs_vec !== '0) begin
        miscompares++; $display("FAIL reset_values: got %h want 0", obs_vec);
      end
    end
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); @(negedge clk);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++; $display("FAIL idle_model c%0d: got %h want %h", i, obs_vec, exp_vec);
      end
      vectors++;
      if ({mem_en, cpu_ack, vid_ack, vid_slot} !== {3'b000, 1'(((i / SC) % 2) == 0)}) begin
        miscompares++;
        $display("FAIL idle_slots c%0d: got %b want %b", i, {mem_en, cpu_ack, vid_ack, vid_slot},
                 {3'b000, 1'(((i / SC) % 2) == 0)});
      end
    end
  endtask

  task automatic test_vid_read();
    ram[16'h0400] = 8'h5A; refmem[16'h0400] = 8'h5A;
    sync_to(3, 0);
    vid_req = 1'b1; vid_addr = 16'h0400;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 3) vid_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++; $display("FAIL vid_read_model k%0d: got %h want %h", k, obs_vec, exp_vec);
      end
      if (k == 0) begin
        vectors++;
        if ({mem_en, mem_we, mem_addr} !== {2'b10, 16'h0400}) begin
          miscompares++; $display("FAIL vid_read_issue: got %b %b %h want 1 0 0400", mem_en, mem_we, mem_addr);
        end
      end
      if (k == 1) begin
        vectors++;
        if (mem_en !== 1'b0) begin
          miscompares++; $display("FAIL vid_read_wait: mem_en got %b want 0", mem_en);
        end
      end
      if (k == 2) begin
        vectors++;
        if ({vid_ack, cpu_ack, vid_rdata} !== {2'b10, 8'h5A}) begin
          miscompares++; $display("FAIL vid_read_ack: got %b %b %h want 1 0 5a", vid_ack, cpu_ack, vid_rdata);
        end
      end
    end
  endtask

  task automatic test_cpu_write_read();
    sync_to(3, 1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'hC3;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 3) cpu_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++; $display("FAIL cpu_write_model k%0d: got %h want %h", k, obs_vec, exp_vec);
      end
      if (k == 0) begin
        vectors++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h2000, 8'hC3}) begin
          miscompares++;
          $display("FAIL cpu_write_issue: got %b %b %h %h want 1 1 2000 c3", mem_en, mem_we, mem_addr, mem_wdata);
        end
      end
      if (k == 2) begin
        vectors++;
        if ({cpu_ack, vid_ack} !== 2'b10) begin
          miscompares++; $display("FAIL cpu_write_ack: got %b %b want 1 0", cpu_ack, vid_ack);
        end
      end
    end
    sync_to(3, 1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_wdata = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 3) cpu_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++; $display("FAIL cpu_read_model k%0d: got %h want %h", k, obs_vec, exp_vec);
      end
      if (k == 2) begin
        vectors++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, 8'hC3}) begin
          miscompares++; $display("FAIL cpu_read_back: got %b %h want 1 c3", cpu_ack, cpu_rdata);
        end
      end
    end
  endtask

  task automatic test_late_req();
    int lat = 0;
    bit got = 0;
    sync_to(1, 0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++; $display("FAIL late_req_model k%0d: got %h want %h", k, obs_vec, exp_vec);
      end
      if (cpu_ack) begin got = 1; lat = k; end
    end
    @(posedge clk); #1 cpu_req = 1'b0;
    vectors++;
    if (lat != 9) begin
      miscompares++; $display("FAIL late_req_latency: got %0d want 9", lat);
    end
    vectors++;
    if (cpu_rdata !== 8'hC3) begin
      miscompares++; $display("FAIL late_req_data: got %h want c3", cpu_rdata);
    end
  endtask

  task automatic test_back_to_back();
    bit cseen = 0, vseen = 0;
    int last_k = -1, acks = 0;
    bit last_vid = 0;
    cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = 16'h3000 + 16'($urandom_range(0, 15));
    cpu_wdata = 8'($urandom);
    vid_req = 1'b1; vid_addr = 16'h3000 + 16'($urandom_range(0, 15));
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (cseen) begin
        cpu_we = 1'($urandom); cpu_addr = 16'h3000 + 16'($urandom_range(0, 15));
        cpu_wdata = 8'($urandom);
      end
      if (vseen) vid_addr = 16'h3000 + 16'($urandom_range(0, 15));
      @(negedge clk);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++; $display("FAIL b2b_model k%0d: got %h want %h", k, obs_vec, exp_vec);
      end
      vectors++;
      if (cpu_ack && vid_ack) begin
        miscompares++; $display("FAIL b2b_both_acks k%0d: got 1 1 want at most one", k);
      end
      cseen = cpu_ack; vseen = vid_ack;
      if (cpu_ack || vid_ack) begin
        if (last_k >= 0) begin
          vectors++;
          if (k - last_k != SC || vid_ack == last_vid) begin
            miscompares++;
            $display("FAIL b2b_alternate k%0d: gap %0d vid %b want gap %0d vid %b",
                     k, k - last_k, vid_ack, SC, !last_vid);
          end
        end
        last_k = k; last_vid = vid_ack; acks++;
      end
    end
    vectors++;
    if (acks < 9) begin
      miscompares++; $display("FAIL b2b_ack_count: got %0d want >= 9", acks);
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++; $display("FAIL b2b_flush k%0d: got %h want %h", k, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    ram[16'h0410] = 8'hA7; refmem[16'h0410] = 8'hA7;
    sync_to(3, 0);
    vid_req = 1'b1; vid_addr = 16'h0410;
    @(posedge clk); #1; @(negedge clk);
    vectors++;
    if (mem_en !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_issue: mem_en got %b want 1", mem_en);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs_vec !== '0) begin
      miscompares++; $display("FAIL rst_mid_cleared: got %h want 0", obs_vec);
    end
    @(posedge clk); #1; @(negedge clk);
    vectors++;
    if ({vid_slot, mem_en, mem_addr} !== {2'b11, 16'h0410}) begin
      miscompares++; $display("FAIL rst_mid_restart: got %b %b %h want 1 1 0410", vid_slot, mem_en, mem_addr);
    end
    @(posedge clk); #1; @(negedge clk);
    @(posedge clk); #1; @(negedge clk);
    vectors++;
    if ({vid_ack, vid_rdata} !== {1'b1, 8'hA7}) begin
      miscompares++; $display("FAIL rst_mid_ack: got %b %h want 1 a7", vid_ack, vid_rdata);
    end
    vectors++;
    if (obs_vec !== exp_vec) begin
      miscompares++; $display("FAIL rst_mid_model: got %h want %h", obs_vec, exp_vec);
    end
    @(posedge clk); #1 vid_req = 1'b0;
  endtask

  task automatic test_random();
    bit cseen = 0, vseen = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (cseen || (!cpu_req && $urandom_range(0, 2) == 0)) begin
        cpu_req = cseen ? 1'($urandom) : 1'b1;
        cpu_we = 1'($urandom); cpu_addr = 16'h3000 + 16'($urandom_range(0, 15));
        cpu_wdata = 8'($urandom);
      end else if (cpu_req && $urandom_range(0, 15) == 0) begin
        cpu_req = 1'b0;
      end
      if (vseen || (!vid_req && $urandom_range(0, 2) == 0)) begin
        vid_req = vseen ? 1'($urandom) : 1'b1;
        vid_addr = 16'h3000 + 16'($urandom_range(0, 15));
      end else if (vid_req && $urandom_range(0, 15) == 0) begin
        vid_req = 1'b0;
      end
      @(negedge clk);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++; $display("FAIL random_model n%0d: got %h want %h", n, obs_vec, exp_vec);
      end
      cseen = cpu_ack; vseen = vid_ack;
    end
    cpu_req = 1'b0; vid_req = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      ram[i] = v;
      refmem[i] = v;
    end
    test_reset();
    test_vid_read();
    test_cpu_write_read();
    test_late_req();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_slot_arbiter.md
# mem_slot_arbiter

Time-division arbiter that shares the single 8-bit system memory between the CPU and the video scanner, clocked directly from CLOCK_50. It alternates fixed-length slots (video slot, then CPU slot) so each requester sees deterministic access timing, matching the mem/cpu phase ratio the clock divider produces. It sits between the CPU/video bus masters and the synchronous RAM.

## Interface
- ADDR_W, 16: address width for both requesters and memory.
- SLOT_CYCLES, 20: CLOCK_50 cycles per slot; legal minimum 3; simulation benches use 4.

- CLOCK_50  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data; valid from cpu_ack, held until next CPU read completes.
- vid_req  in  1  video read request; held until vid_ack.
- vid_addr  in  ADDR_W  video address.
- vid_ack  out  1  one-cycle completion pulse.
- vid_rdata  out  8  video read data; same hold rule as cpu_rdata.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  RAM read data; valid one cycle after the edge that samples mem_en.
- vid_slot  out  1  1 while the current slot belongs to video.

## Operation
- Slot timer: cnt counts 0..SLOT_CYCLES-1 and wraps; owner toggles on every wrap. Order is VID, CPU, VID, ...
- Fixed TDM: an unused slot is not given to the other requester.
- Grant: at the edge where cnt becomes 0, latch the new owner's req/we/addr/wdata. If req is low, the slot stays idle.
- Transaction FSM: IDLE -> ISSUE (mem_en=1, bus driven) -> WAIT (mem_en=0, RAM output settling) -> DONE (owner's ack=1, rdata updated if read) -> IDLE.
- Video requests are always treated as reads (mem_we=0).
- A request raised after cnt=0 of its owner's slot waits for that owner's next slot.
- If req is still high in the cycle after ack, it is a new request, served in the owner's next slot.
- If req drops before ack, the latched transaction still completes and ack still pulses.
- Writes: ack pulses at the same point as reads; cpu_rdata is unchanged.
- mem_addr, mem_we and mem_wdata hold their last values when mem_en=0. Only mem_en qualifies the bus.

## Timing
- Reset values: cnt=SLOT_CYCLES-1, owner=CPU, FSM=IDLE, all outputs 0. vid_slot is 0 during reset.
- The first edge after reset deasserts starts a video slot at cnt=0.
- Cycle offsets within a granted slot:
  - cnt=0: mem_en high.
  - cnt=1: mem_en low; RAM data on mem_rdata.
  - cnt=2: ack high and rdata valid.
- Latency from slot start to ack is 2 cycles. Worst-case from req to ack is 2*SLOT_CYCLES+2 cycles.
- Exactly one ack per granted slot, never both acks at once.
- vid_slot changes on the same edge as cnt wraps to 0.
- Reset mid-transaction aborts it: no ack, mem_en=0 on that edge, and the timer restarts as in the reset values above.

## Structure
- computer_pkg (shared package) holds:
  - slot_owner_e {SLOT_VID, SLOT_CPU};
  - arb_state_e {IDLE, ISSUE, WAIT, DONE};
  - DATA_W=8.
- Sub-module slot_timer (parameter SLOT_CYCLES; outputs cnt, owner, slot_start). The arbiter instantiates it once; the grant/FSM logic stays in mem_slot_arbiter.

## Test plan
All scenarios use SLOT_CYCLES=4.
- Reset release, no requests: vid_slot toggles every 4 cycles starting at 1; mem_en never asserts; both acks stay 0.
- vid_req at addr 0x0400, RAM holds 0x5A: mem_en=1 with mem_addr=0x0400 at video cnt=0; vid_ack at cnt=2 with vid_rdata=0x5A; cpu_ack stays 0.
- CPU write 0xC3 to 0x2000, then CPU read of 0x2000: write completes in the first CPU slot with mem_we=1; the read in the next CPU slot returns cpu_rdata=0xC3.
- Both requesters held high continuously: acks alternate vid_ack, cpu_ack every 4 cycles; never simultaneous.
- cpu_req raised at CPU cnt=1: no access in that slot; ack comes at cnt=2 of the next CPU slot, 9 cycles after req.
- reset asserted at cnt=1 of a granted video read: no vid_ack; mem_en=0; after release, timing restarts with a video slot at cnt=0.
